// File: rtl/mini_alu_pipe.sv
// rtl/mini_alu_pipe.sv - two-stage fetch/execute mini core with forwarding, branch flush and iterative SMUL
module mini_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [IP_W-1:0]       oIP,
    input  logic [4+3*ADDR_W-1:0] iInstruction,
    output logic [LED_W-1:0]      oLed,
    output logic                  oStall
);
    localparam int INSTR_W = 4 + 3 * ADDR_W;
    localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int NREGS   = 2 ** ADDR_W;

    localparam logic [3:0] OP_LED  = 4'd1;
    localparam logic [3:0] OP_BLE  = 4'd2;
    localparam logic [3:0] OP_STO  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_SMUL = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MFH  = 4'd10;

    logic [IP_W-1:0]     ip_q, ip_d;
    logic [INSTR_W-1:0]  ex_instr_q, ex_instr_d;
    logic [DATA_W-1:0]   ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stall_q, stall_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   rf_q [NREGS];

    logic [3:0]          ex_op;
    logic [ADDR_W-1:0]   ex_dst, f_s1, f_s0;
    logic [DATA_W-1:0]   ex_imm;
    logic [IP_W-1:0]     branch_ip;
    logic [2*DATA_W-1:0] mul_pp, mul_sum;
    logic                wr_en, branch;
    logic [DATA_W-1:0]   wr_data;
    logic [INSTR_W-1:0]  fetch_instr;

    assign ex_op  = ex_instr_q[INSTR_W-1 -: 4];
    assign ex_dst = ex_instr_q[3*ADDR_W-1 -: ADDR_W];
    assign f_s1   = iInstruction[2*ADDR_W-1 -: ADDR_W];
    assign f_s0   = iInstruction[ADDR_W-1:0];

    generate
        if (DATA_W > 2 * ADDR_W) begin : g_imm_ext
            assign ex_imm = {{(DATA_W - 2 * ADDR_W){1'b0}}, ex_instr_q[2*ADDR_W-1:0]};
        end else begin : g_imm_trunc
            assign ex_imm = ex_instr_q[DATA_W-1:0];
        end
        if (IP_W > ADDR_W) begin : g_ip_ext
            assign branch_ip = {{(IP_W - ADDR_W){1'b0}}, ex_dst};
        end else begin : g_ip_trunc
            assign branch_ip = ex_dst[IP_W-1:0];
        end
    endgenerate

    // One partial product per cycle; the sum on the last cycle is the full product.
    assign mul_pp  = ex_b_q[cnt_q] ? ({{DATA_W{1'b0}}, ex_a_q} << cnt_q) : '0;
    assign mul_sum = prod_q + mul_pp;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        branch  = 1'b0;
        led_d   = led_q;
        hi_d    = hi_q;
        case (ex_op)
            OP_LED:  led_d = ex_a_q[LED_W-1:0];
            OP_BLE:  branch = (ex_a_q <= ex_b_q);
            OP_STO:  begin wr_en = 1'b1; wr_data = ex_imm; end
            OP_ADD:  begin wr_en = 1'b1; wr_data = ex_a_q + ex_b_q; end
            OP_JMP:  branch = 1'b1;
            OP_SMUL: begin
                if (!stall_q) begin
                    wr_en   = 1'b1;
                    wr_data = mul_sum[DATA_W-1:0];
                    hi_d    = mul_sum[2*DATA_W-1:DATA_W];
                end
            end
            OP_SUB:  begin wr_en = 1'b1; wr_data = ex_a_q - ex_b_q; end
            OP_SHL:  begin wr_en = 1'b1; wr_data = ex_a_q << ex_b_q[3:0]; end
            OP_SHR:  begin wr_en = 1'b1; wr_data = ex_a_q >> ex_b_q[3:0]; end
            OP_MFH:  begin wr_en = 1'b1; wr_data = hi_q; end
            default: ;
        endcase
    end

    always_comb begin
        fetch_instr = branch ? '0 : iInstruction;
        ip_d        = ip_q;
        ex_instr_d  = ex_instr_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        prod_d      = prod_q;
        if (stall_q) begin
            cnt_d   = cnt_q + 1'b1;
            stall_d = (cnt_q != CNT_W'(DATA_W - 2));
            prod_d  = mul_sum;
        end else begin
            ip_d       = branch ? branch_ip : ip_q + 1'b1;
            ex_instr_d = fetch_instr;
            ex_a_d     = (wr_en && ex_dst == f_s1) ? wr_data : rf_q[f_s1];
            ex_b_d     = (wr_en && ex_dst == f_s0) ? wr_data : rf_q[f_s0];
            cnt_d      = '0;
            prod_d     = '0;
            stall_d    = (fetch_instr[INSTR_W-1 -: 4] == OP_SMUL) && (DATA_W > 1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ip_q       <= '0;
            ex_instr_q <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            led_q      <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
            prod_q     <= '0;
        end else begin
            ip_q       <= ip_d;
            ex_instr_q <= ex_instr_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            led_q      <= led_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            stall_q    <= stall_d;
            prod_q     <= prod_d;
        end
    end

    // Register file has no reset; EX is a NOP during reset so no write can fire.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            rf_q[ex_dst] <= wr_data;
        end
    end

    assign oIP    = ip_q;
    assign oLed   = led_q;
    assign oStall = stall_q;
endmodule

// File: tb/tb_mini_alu_pipe.sv
// tb/tb_mini_alu_pipe.sv - directed self-checking bench for mini_alu_pipe
module tb_mini_alu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ip;
    logic [27:0] instr;
    logic [7:0]  led;
    logic        stall;
    logic [3:0]  ip_s;
    logic [27:0] nop_instr = '0;
    logic [7:0]  led_s;
    logic        stall_s;
    logic [27:0] rom [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt;

    always #5 clk = ~clk;

    assign instr = rom[ip[7:0]];

    mini_alu_pipe dut (
        .Clock(clk), .Reset(rst), .oIP(ip), .iInstruction(instr), .oLed(led), .oStall(stall)
    );

    mini_alu_pipe #(.IP_W(4)) dut_s (
        .Clock(clk), .Reset(rst), .oIP(ip_s), .iInstruction(nop_instr), .oLed(led_s), .oStall(stall_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
        return {4'd3, d, imm};
    endfunction

    task automatic begin_test();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        // NOP ROM: reset state, sequential fetch, 4-bit IP wrap
        begin_test();
        release_reset();
        check("rst_ip", ip, 0);
        check("rst_led", led, 0);
        check("rst_stall", stall, 0);
        check("rst_ip_s", ip_s, 0);
        stall_cnt = 0;
        for (int e = 1; e <= 16; e++) begin
            goto_edge(e);
            stall_cnt += int'(stall);
            if (e <= 3) check("nop_ip_seq", ip, e);
            if (e == 15) check("wrap_ip15", ip_s, 15);
            if (e == 16) check("wrap_ip0", ip_s, 0);
        end
        check("nop_stall", stall_cnt, 0);
        check("nop_led", led, 0);

        // STO/ADD/LED with forwarding
        begin_test();
        rom[0] = sto(1, 16'd5);
        rom[1] = sto(2, 16'd7);
        rom[2] = ins(4, 3, 2, 1);
        rom[3] = ins(1, 0, 3, 0);
        release_reset();
        goto_edge(4);
        check("add_led_early", led, 0);
        goto_edge(5);
        check("add_led", led, 8'h0C);
        check("add_r3", dut.rf_q[3], 16'd12);

        // BLE taken on equality: flush and redirect
        begin_test();
        rom[0]    = sto(6, 16'h11);
        rom[1]    = sto(1, 16'd3);
        rom[2]    = sto(2, 16'd3);
        rom[3]    = ins(2, 8'h20, 2, 1);
        rom[4]    = sto(6, 16'h99);
        rom[8'h20] = ins(1, 0, 6, 0);
        release_reset();
        goto_edge(4);
        check("ble_t_ip_pre", ip, 4);
        goto_edge(5);
        check("ble_t_ip", ip, 16'h20);
        goto_edge(8);
        check("ble_t_flush_led", led, 8'h11);
        check("ble_t_flush_r6", dut.rf_q[6], 16'h11);

        // BLE not taken: sequential flow
        rom[2] = sto(2, 16'd4);
        rom[5] = ins(1, 0, 6, 0);
        rst = 1'b1;
        release_reset();
        goto_edge(5);
        check("ble_nt_ip", ip, 5);
        goto_edge(8);
        check("ble_nt_led", led, 8'h99);

        // SMUL 0xFFFF*2, stall length, forwarding, MFH, JMP
        begin_test();
        rom[0] = sto(1, 16'hFFFF);
        rom[1] = sto(2, 16'h0002);
        rom[2] = ins(6, 3, 1, 2);
        rom[3] = ins(4, 5, 3, 3);
        rom[4] = ins(10, 4, 0, 0);
        rom[5] = ins(1, 0, 4, 0);
        rom[6] = ins(5, 8'h40, 0, 0);
        release_reset();
        goto_edge(2);
        check("smul_stall_pre", stall, 0);
        stall_cnt = 0;
        for (int e = 3; e <= 17; e++) begin
            goto_edge(e);
            stall_cnt += int'(stall);
        end
        check("smul_stall_len", stall_cnt, 15);
        check("smul_ip_frozen", ip, 3);
        goto_edge(18);
        check("smul_last_stall", stall, 0);
        check("smul_last_ip", ip, 3);
        goto_edge(19);
        check("smul_adv_ip", ip, 4);
        goto_edge(23);
        check("jmp_ip", ip, 16'h40);
        check("mfh_led", led, 8'h01);
        check("smul_lo", dut.rf_q[3], 16'hFFFE);
        check("mfh_r4", dut.rf_q[4], 16'h0001);
        check("smul_fwd_add", dut.rf_q[5], 16'hFFFC);

        // SUB/SHL/SHR edge values, back-to-back SMUL
        begin_test();
        rom[0] = sto(1, 16'd0);
        rom[1] = sto(2, 16'd1);
        rom[2] = ins(7, 3, 1, 2);
        rom[3] = sto(4, 16'd15);
        rom[4] = ins(8, 5, 2, 4);
        rom[5] = ins(9, 6, 5, 4);
        rom[6] = sto(7, 16'h1234);
        rom[7] = ins(6, 8, 7, 7);
        rom[8] = ins(6, 9, 8, 7);
        rom[9] = ins(10, 10, 0, 0);
        release_reset();
        goto_edge(23);
        check("b2b_last1", stall, 0);
        goto_edge(24);
        check("b2b_restart", stall, 1);
        check("b2b_ip", ip, 9);
        goto_edge(40);
        check("b2b_adv_ip", ip, 10);
        goto_edge(45);
        check("sub_wrap", dut.rf_q[3], 16'hFFFF);
        check("shl15", dut.rf_q[5], 16'h8000);
        check("shr15", dut.rf_q[6], 16'h0001);
        check("smul1_lo", dut.rf_q[8], 16'h5A90);
        check("smul2_lo", dut.rf_q[9], 16'h8540);
        check("smul2_hi", dut.rf_q[10], 16'h0670);

        // Reset 5 cycles into an SMUL aborts it
        begin_test();
        rom[0] = sto(1, 16'hFFFF);
        rom[1] = sto(3, 16'h0055);
        rom[2] = ins(6, 4, 1, 1);
        rom[3] = sto(2, 16'd3);
        rom[4] = ins(6, 3, 1, 2);
        release_reset();
        goto_edge(25);
        check("abort_pre_stall", stall, 1);
        check("abort_pre_ip", ip, 5);
        check("abort_pre_hi", dut.hi_q, 16'hFFFE);
        check("abort_r4", dut.rf_q[4], 16'h0001);
        rst = 1'b1;
        #1;
        check("abort_stall", stall, 0);
        check("abort_ip", ip, 0);
        check("abort_hi", dut.hi_q, 0);
        repeat (3) @(negedge clk);
        check("abort_r3", dut.rf_q[3], 16'h0055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
